// File: rtl/bcd_trigger_counter.sv
// rtl/bcd_trigger_counter.sv - packed-BCD trigger counter with rippled carry and refresh-latched display
module bcd_trigger_counter #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_clk,
    input  logic [DIGITS-1:0]     trigger,
    input  logic                  ref_clk,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  busy,
    output logic                  ref_done,
    output logic                  overflow,
    output logic                  missed
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RIPPLE = 1'b1
    } state_t;

    // Index of the most significant digit; the ripple ends after processing it.
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    state_t                state_q,       state_d;
    logic [4*DIGITS-1:0]   work_q,        work_d;
    logic [DIGITS-1:0]     mask_q,        mask_d;
    logic [3:0]            idx_q,         idx_d;
    logic                  carry_q,       carry_d;
    logic                  ref_pending_q, ref_pending_d;
    logic [4*DIGITS-1:0]   count_q,       count_d;
    logic                  ref_done_q,    ref_done_d;
    logic                  overflow_q,    overflow_d;
    logic                  missed_q,      missed_d;

    logic [3:0]            cur_digit;
    logic                  cur_mask;
    logic [4:0]            digit_sum;
    logic                  digit_wrap;
    logic [3:0]            next_digit;

    // Select the digit and mask bit currently addressed by the ripple index.
    always_comb begin
        cur_digit = '0;
        cur_mask  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_digit = work_q[4*i +: 4];
                cur_mask  = mask_q[i];
            end
        end
    end

    // One BCD digit add: digit + request + incoming carry never exceeds 11.
    assign digit_sum  = {1'b0, cur_digit} + {4'b0000, cur_mask} + {4'b0000, carry_q};
    assign digit_wrap = (digit_sum >= 5'd10);
    assign next_digit = digit_wrap ? 4'(digit_sum - 5'd10) : digit_sum[3:0];

    // Next-state logic: ripple sequencing, refresh copy/deferral and sticky flags.
    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        mask_d        = mask_q;
        idx_d         = idx_q;
        carry_d       = carry_q;
        ref_pending_d = ref_pending_q;
        count_d       = count_q;
        ref_done_d    = 1'b0;
        overflow_d    = overflow_q;
        missed_d      = missed_q;

        case (state_q)
            IDLE: begin
                // The copy takes the pre-increment value when inc and ref coincide.
                if (ref_clk || ref_pending_q) begin
                    count_d       = work_q;
                    ref_done_d    = 1'b1;
                    ref_pending_d = 1'b0;
                end
                // An all-zero mask still walks every digit so busy timing is fixed.
                if (inc_clk) begin
                    mask_d  = trigger;
                    idx_d   = 4'd0;
                    carry_d = 1'b0;
                    state_d = RIPPLE;
                end
            end

            RIPPLE: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == 4'(i)) begin
                        work_d[4*i +: 4] = next_digit;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // Carry out of the top digit is dropped: count wraps modulo 10^DIGITS.
                    carry_d    = 1'b0;
                    overflow_d = overflow_q | digit_wrap;
                    state_d    = IDLE;
                end else begin
                    carry_d = digit_wrap;
                    idx_d   = idx_q + 4'd1;
                end
                // The display must not show a half-rippled value; defer the copy.
                if (ref_clk) begin
                    ref_pending_d = 1'b1;
                end
                // A new increment cannot be queued; the ripple in flight is untouched.
                if (inc_clk) begin
                    missed_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any ripple in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            work_q        <= '0;
            mask_q        <= '0;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            ref_pending_q <= 1'b0;
            count_q       <= '0;
            ref_done_q    <= 1'b0;
            overflow_q    <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            mask_q        <= mask_d;
            idx_q         <= idx_d;
            carry_q       <= carry_d;
            ref_pending_q <= ref_pending_d;
            count_q       <= count_d;
            ref_done_q    <= ref_done_d;
            overflow_q    <= overflow_d;
            missed_q      <= missed_d;
        end
    end

    assign count_out = count_q;
    assign busy      = (state_q == RIPPLE);
    assign ref_done  = ref_done_q;
    assign overflow  = overflow_q;
    assign missed    = missed_q;

endmodule

// File: tb/tb_bcd_trigger_counter.sv
// tb/tb_bcd_trigger_counter.sv - directed self-checking bench for bcd_trigger_counter
module tb_bcd_trigger_counter;

    localparam int DIGITS = 6;

    logic                clk;
    logic                reset;
    logic                inc_clk;
    logic [DIGITS-1:0]   trigger;
    logic                ref_clk;
    logic [4*DIGITS-1:0] count_out;
    logic                busy;
    logic                ref_done;
    logic                overflow;
    logic                missed;

    int errors = 0;
    int checks = 0;
    int busy_cnt;

    bcd_trigger_counter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .inc_clk   (inc_clk),
        .trigger   (trigger),
        .ref_clk   (ref_clk),
        .count_out (count_out),
        .busy      (busy),
        .ref_done  (ref_done),
        .overflow  (overflow),
        .missed    (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse inc for one edge, then sample busy over the next 12 cycles.
    task automatic do_inc(input logic [DIGITS-1:0] m);
        inc_clk = 1'b1;
        trigger = m;
        @(negedge clk);
        inc_clk  = 1'b0;
        trigger  = '0;
        busy_cnt = 0;
        repeat (12) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_ref();
        ref_clk = 1'b1;
        @(negedge clk);
        ref_clk = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        inc_clk = 1'b0;
        trigger = '0;
        ref_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_count",    count_out, 24'h000000);
        check("rst_busy",     busy,      1'b0);
        check("rst_ref_done", ref_done,  1'b0);
        check("rst_overflow", overflow,  1'b0);
        check("rst_missed",   missed,    1'b0);

        // Three single-digit increments, busy exactly DIGITS cycles each
        for (int k = 0; k < 3; k++) begin
            do_inc(6'b000001);
            check("t1_busy_cycles", busy_cnt, 6);
            repeat (7) @(negedge clk);
        end
        do_ref();
        check("t1_ref_done", ref_done,  1'b1);
        check("t1_count",    count_out, 24'h000003);
        @(negedge clk);
        check("t1_ref_done_drop", ref_done, 1'b0);

        // 99 + 1 ripples two carries -> 100
        do_reset();
        for (int k = 0; k < 9; k++) do_inc(6'b000001);
        for (int k = 0; k < 9; k++) do_inc(6'b000010);
        do_inc(6'b000001);
        repeat (5) @(negedge clk);
        do_ref();
        check("t2_count",    count_out, 24'h000100);
        check("t2_overflow", overflow,  1'b0);

        // 999999 + 1 wraps to zero and sets overflow
        do_reset();
        for (int k = 0; k < 9; k++) do_inc(6'b111111);
        do_ref();
        check("t3_preload", count_out, 24'h999999);
        check("t3_no_ovf",  overflow,  1'b0);
        do_inc(6'b000001);
        do_ref();
        check("t3_count",    count_out, 24'h000000);
        check("t3_overflow", overflow,  1'b1);
        do_inc(6'b000001);
        check("t3_ovf_sticky", overflow, 1'b1);

        // Simultaneous inc and ref copies the pre-increment value
        do_reset();
        for (int k = 0; k < 5; k++) do_inc(6'b000001);
        inc_clk = 1'b1;
        trigger = 6'b000001;
        ref_clk = 1'b1;
        @(negedge clk);
        inc_clk = 1'b0;
        trigger = '0;
        ref_clk = 1'b0;
        check("t4_ref_done", ref_done,  1'b1);
        check("t4_count",    count_out, 24'h000005);
        check("t4_busy",     busy,      1'b1);
        repeat (10) @(negedge clk);
        do_ref();
        check("t4_count2", count_out, 24'h000006);

        // Deferred refresh during ripple plus an ignored second inc
        inc_clk = 1'b1;
        trigger = 6'b000001;
        @(negedge clk);                 // after E0
        inc_clk = 1'b0;
        trigger = '0;
        @(negedge clk);                 // after E0+1
        ref_clk = 1'b1;
        @(negedge clk);                 // after E0+2 (ref sampled mid-ripple)
        ref_clk = 1'b0;
        check("t5_hold_count",    count_out, 24'h000006);
        check("t5_hold_ref_done", ref_done,  1'b0);
        inc_clk = 1'b1;
        trigger = 6'b000001;
        @(negedge clk);                 // after E0+3
        inc_clk = 1'b0;
        trigger = '0;
        check("t5_missed",     missed,    1'b1);
        check("t5_busy_mid",   busy,      1'b1);
        check("t5_count_mid",  count_out, 24'h000006);
        repeat (3) @(negedge clk);      // after E0+6
        check("t5_busy_end",   busy,      1'b0);
        check("t5_no_copy_yet", ref_done, 1'b0);
        @(negedge clk);                 // after E0+7
        check("t5_def_ref_done", ref_done,  1'b1);
        check("t5_def_count",    count_out, 24'h000007);
        @(negedge clk);
        check("t5_ref_done_drop", ref_done, 1'b0);
        check("t5_missed_sticky", missed,   1'b1);

        // Reset mid-ripple leaves no partial result
        do_reset();
        for (int k = 0; k < 9; k++) do_inc(6'b000111);
        inc_clk = 1'b1;
        trigger = 6'b000001;
        @(negedge clk);                 // after E0
        inc_clk = 1'b0;
        trigger = '0;
        repeat (2) @(negedge clk);      // after E0+2
        reset = 1'b1;
        @(negedge clk);                 // after E0+3
        reset = 1'b0;
        check("t6_count",    count_out, 24'h000000);
        check("t6_busy",     busy,      1'b0);
        check("t6_ref_done", ref_done,  1'b0);
        check("t6_overflow", overflow,  1'b0);
        check("t6_missed",   missed,    1'b0);
        do_inc(6'b000001);
        do_ref();
        check("t6_after", count_out, 24'h000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
